cic_comb: RTL

CIC_COMB -- requirements
Module: cic_comb

---
 rtl/cic_comb.sv | 106 ++++++++++
 1 files changed

// File: rtl/cic_comb.sv
// cic_comb -- comb half of a CIC decimator.
//
// A cascade of NumStages comb sections, each computing
//   y[n] = x[n] - x[n - DifferentialDelay]
// on the decimated sample stream. Arithmetic is two's complement and wraps
// modulo 2^WordLengthBits on purpose: the upstream integrators overflow
// freely and the comb differences undo that wrap exactly.
//
// The sample index only advances on an accepted input, so idle cycles do
// not enter the delay lines. The result is registered (1 cycle latency)
// behind a single-entry valid/ready output stage.
//
// Parameters:
//   WordLengthBits    signed width of in and out
//   NumStages         number of cascaded comb sections (1..8)
//   DifferentialDelay comb delay M per section (1 or 2)
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        asynchronous active-low reset
//   in         decimated input sample
//   in_valid   in holds a sample
//   in_ready   block accepts in this cycle
//   out        registered comb cascade result
//   out_valid  out holds an unconsumed result
//   out_ready  downstream consumes out this cycle

module cic_comb #(
  parameter int WordLengthBits    = 12,
  parameter int NumStages         = 3,
  parameter int DifferentialDelay = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [WordLengthBits-1:0] in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic signed [WordLengthBits-1:0] out,
  output logic                             out_valid,
  input  logic                             out_ready
);

  // delay_line[k][0] is the newest stored input of section k,
  // delay_line[k][DifferentialDelay-1] is x_k[n-M].
  logic signed [WordLengthBits-1:0] delay_line [NumStages][DifferentialDelay];

  // Input of each section for the sample currently on in, and the
  // final cascade output.
  logic signed [WordLengthBits-1:0] stage_in [NumStages];
  logic signed [WordLengthBits-1:0] comb_result;

  logic accept;

  // The output register is the only buffer, so a new sample can enter
  // whenever that register is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Ripple the sample through all sections with a running accumulator so
  // the per-stage taps are only written here and never read back, which
  // keeps the combinational path free of self-referencing arrays.
  always_comb begin
    logic signed [WordLengthBits-1:0] acc;
    acc = in;
    for (int k = 0; k < NumStages; k++) begin
      stage_in[k] = acc;
      acc         = acc - delay_line[k][DifferentialDelay-1];
    end
    comb_result = acc;
  end

  // Delay lines shift only on an accepted input; a stalled or idle cycle
  // is not a sample and must leave the history untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NumStages; k++) begin
        for (int m = 0; m < DifferentialDelay; m++) begin
          delay_line[k][m] <= '0;
        end
      end
    end else if (accept) begin
      for (int k = 0; k < NumStages; k++) begin
        delay_line[k][0] <= stage_in[k];
        for (int m = 1; m < DifferentialDelay; m++) begin
          delay_line[k][m] <= delay_line[k][m-1];
        end
      end
    end
  end

  // Output stage: a new result overwrites out (even while the old one is
  // being consumed, giving one sample per cycle); a consume without a new
  // sample only drops out_valid and leaves the data in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= comb_result;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
